// File: rtl/store_unit_rmw.sv
// store_unit_rmw
//   Multi-cycle RV32I store engine (SB/SH/SW) between execute and a word-wide
//   data RAM. Sub-word stores use read-modify-write. Aligned SW is written
//   directly. Misaligned SH/SW either trap or are split across two words,
//   depending on MISALIGN_SPLIT.
// Ports
//   iCLK, iRST_N          clock, async active-low reset
//   iSTART                accept a store (sampled only when idle)
//   iFUNC3                0=SB 1=SH 2=SW, others illegal
//   iBASE, iIMM, iDATA    rs1, S-type immediate, rs2
//   oBUSY/oDONE/oFAULT    status; DONE/FAULT are 1-cycle pulses
//   oRAM_*                RAM strobes, word address, write data
//   iRAM_DATA             RAM read data, one cycle after oRAM_RD
module store_unit_rmw #(
  parameter int unsigned ADDR_W         = 8,
  parameter bit          MISALIGN_SPLIT = 1'b0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic [2:0]        iFUNC3,
  input  logic [31:0]       iBASE,
  input  logic [11:0]       iIMM,
  input  logic [31:0]       iDATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oFAULT,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  input  logic [31:0]       iRAM_DATA,
  output logic [31:0]       oRAM_DATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wa0_q, wa0_d;
  logic               second_q, second_d;
  logic [63:0]        lane_q, lane_d;
  logic [7:0]         mask_q, mask_d;
  logic [31:0]        wdata_q, wdata_d;

  // Accept-time decode, only meaningful in IDLE.
  logic [31:0]        ea;
  logic [1:0]         off;
  logic               misaligned;
  logic               illegal;
  logic [7:0]         mask_base;
  logic [ADDR_W-1:0]  cur_wa;
  logic [3:0]         sel_mask;
  logic [31:0]        sel_lane;
  logic [31:0]        merged;
  logic               unused_ea_hi;

  assign ea           = iBASE + {{20{iIMM[11]}}, iIMM};
  assign off          = ea[1:0];
  assign illegal      = (iFUNC3 > 3'd2);
  assign misaligned   = ((iFUNC3 == 3'd1) && (off == 2'd3)) ||
                        ((iFUNC3 == 3'd2) && (off != 2'd0));
  assign unused_ea_hi = ^ea[31:ADDR_W+2];

  always_comb begin
    case (iFUNC3)
      3'd0:    mask_base = 8'h01;
      3'd1:    mask_base = 8'h03;
      default: mask_base = 8'h0F;
    endcase
  end

  // Second word wraps naturally at the top of the RAM.
  assign cur_wa   = second_q ? (wa0_q + ADDR_W'(1)) : wa0_q;
  assign sel_mask = second_q ? mask_q[7:4]   : mask_q[3:0];
  assign sel_lane = second_q ? lane_q[63:32] : lane_q[31:0];

  always_comb begin
    merged = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      merged[8*k +: 8] = sel_mask[k] ? sel_lane[8*k +: 8] : iRAM_DATA[8*k +: 8];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      wa0_q    <= '0;
      second_q <= 1'b0;
      lane_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wa0_q    <= wa0_d;
      second_q <= second_d;
      lane_q   <= lane_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wa0_d     = wa0_q;
    second_d  = second_q;
    lane_d    = lane_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    oBUSY     = (state_q != S_IDLE);
    oDONE     = 1'b0;
    oFAULT    = 1'b0;
    oRAM_CE   = 1'b0;
    oRAM_RD   = 1'b0;
    oRAM_WR   = 1'b0;
    oRAM_ADDR = '0;
    oRAM_DATA = '0;

    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          wa0_d    = ea[ADDR_W+1:2];
          second_d = 1'b0;
          lane_d   = {32'b0, iDATA} << {off, 3'b000};
          mask_d   = mask_base << off;
          wdata_d  = iDATA;
          if (illegal || (misaligned && !MISALIGN_SPLIT)) begin
            state_d = S_FAULT;
          end else if ((iFUNC3 == 3'd2) && (off == 2'd0)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        oRAM_CE   = 1'b1;
        oRAM_RD   = 1'b1;
        oRAM_ADDR = cur_wa;
        state_d   = S_MERGE;
      end
      S_MERGE: begin
        wdata_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        oRAM_CE   = 1'b1;
        oRAM_WR   = 1'b1;
        oRAM_ADDR = cur_wa;
        oRAM_DATA = wdata_q;
        // Only a split store has mask bits in the upper word.
        if (!second_q && (mask_q[7:4] != 4'h0)) begin
          second_d = 1'b1;
          state_d  = S_READ;
        end else begin
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        oDONE   = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        oFAULT  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
